// File: rtl/counter_pkg.sv
// counter_pkg: shared defaults for the free-running counter.
// Only parameter defaults live here. Each instance still sets WIDTH and
// RESET_VALUE through its own module parameters.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_RESET_VALUE = 0;

endpackage : counter_pkg

// File: rtl/counter.sv
// counter: free-running WIDTH-bit up-counter with synchronous active-high reset.
//   out   (output, WIDTH) : current count, driven straight from the register
//   clk   (input)         : rising-edge clock
//   reset (input)         : synchronous, active-high; loads RESET_VALUE
// The port order (out, clk, reset) is kept so that positional instantiations
// written for the original block still connect correctly.
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             reset
);

  // RESET_VALUE is truncated to the counter width.
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Incrementer. It wraps modulo 2^WIDTH through natural overflow.
  always_comb begin
    count_d = count_q + WIDTH'(1);
  end

  // Count register. Reset takes priority over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign out = count_q;

endmodule : counter

// File: tb/tb_counter.sv
// tb_counter: randomized, self-checking bench for counter.
// Two instances are exercised: the default 8-bit instance with reset value 0,
// and a 4-bit instance with reset value 5.
module tb_counter;

  logic       clk;
  logic       reset;
  logic       reset4;
  logic [7:0] out8;
  logic [3:0] out4;

  int checks;
  int failures;

  counter dut8 (
    .out   (out8),
    .clk   (clk),
    .reset (reset)
  );

  counter #(.WIDTH(4), .RESET_VALUE(5)) dut4 (
    .out   (out4),
    .clk   (clk),
    .reset (reset4)
  );

  // Clock: period 10, first rising edge at t=5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: the count equals the reset value plus the number of
  // non-reset edges since the most recent reset edge, taken mod 2^W.
  longint edges8, edges4;
  bit     valid8, valid4;
  bit     rst_at_edge8;
  bit     wrap_seen8;
  longint prev8;

  initial begin
    valid8 = 0; valid4 = 0; edges8 = 0; edges4 = 0;
    wrap_seen8 = 0; prev8 = 0; rst_at_edge8 = 0;
  end

  always @(posedge clk) begin
    rst_at_edge8 = reset;
    if (reset) begin edges8 = 0; valid8 = 1; end
    else edges8 = edges8 + 1;
    if (reset4) begin edges4 = 0; valid4 = 1; end
    else edges4 = edges4 + 1;
    #1;
    if (valid8) begin
      check("model8", longint'(out8), (0 + edges8) % 256);
      if (!rst_at_edge8 && prev8 == 255 && out8 == 8'h00) wrap_seen8 = 1;
      prev8 = longint'(out8);
    end
    if (valid4) check("model4", longint'(out4), (5 + edges4) % 16);
  end

  // Scenario for the 4-bit instance: reset held for 3 edges, release, then wrap.
  initial begin
    reset4 = 1'b0;
    #17 reset4 = 1'b1;                     // edges 25, 35 and 45 sample reset
    #9  check("w4_hold_e1", longint'(out4), 5);   // t=26
    #10 check("w4_hold_e2", longint'(out4), 5);   // t=36
    #10 check("w4_hold_e3", longint'(out4), 5);   // t=46
    #2  reset4 = 1'b0;                     // t=48
    #8  check("w4_first_after", longint'(out4), 6); // t=56
    #90 check("w4_at_f", longint'(out4), 15);       // t=146
    #10 check("w4_wrap0", longint'(out4), 0);       // t=156
  end

  // Main scenario for the 8-bit instance, followed by randomized reset traffic.
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    #17 reset = 1'b1;                                // t=17
    #9  check("rst_t25", longint'(out8), 0);         // t=26
    #2  reset = 1'b0;                                // t=28
    #8  check("run_t35", longint'(out8), 1);         // t=36
    #10 check("run_t45", longint'(out8), 2);         // t=46
    #10 check("run_t55", longint'(out8), 3);         // t=56
    #1  reset = 1'b1;                                // t=57
    #9  check("midrst_t65", longint'(out8), 0);      // t=66
    #2  reset = 1'b0;                                // t=68
    #8  check("after_t75", longint'(out8), 1);       // t=76
    #90 check("free_t165", longint'(out8), 10);      // t=166

    // Free-run far enough to pass 0xFF -> 0x00.
    repeat (260) @(negedge clk);
    check("wrap_seen8", longint'(wrap_seen8), 1);

    // Reset pulses that lie between clock edges must have no effect.
    repeat (5) begin
      @(posedge clk);
      #2 reset = 1'b1;
      #3 reset = 1'b0;
    end

    // Randomized reset traffic on both instances.
    repeat (600) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 15) == 0);
      reset4 = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) begin
        // Short glitch that stays clear of the next rising edge.
        #1 reset = ~reset;
        #1 reset = ~reset;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    reset4 = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout at t=%0t: actual=running expected=finished", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_counter

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; SHALL be legal for any value >= 1.
REQ-002 Parameter RESET_VALUE, default 0: value loaded on reset; SHALL be truncated to WIDTH bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates SHALL occur on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port out, output, WIDTH bits: current count value, driven directly from a register.
REQ-006 Positional port order SHALL be (out, clk, reset), so existing positional instantiations connect unchanged.

Function
REQ-007 On each rising clk edge with reset=0, out SHALL become (out + 1) mod 2^WIDTH.
REQ-008 Wrap-around: out = 2^WIDTH-1 (0xFF at default width) SHALL be followed by 0 on the next non-reset edge, with no flag or stall.
REQ-009 Latency: a change on reset SHALL take effect at the first rising clk edge at which it is sampled; out SHALL change only at rising clk edges.
REQ-010 out SHALL be glitch-free, with no combinational path from any input to out.
REQ-011 There are no enable, load, or direction controls; the counter increments on every non-reset edge.
REQ-012 The first non-reset edge after reset deasserts SHALL produce RESET_VALUE+1 (1 at default).

Reset
REQ-013 At a rising clk edge with reset=1, out SHALL be loaded with RESET_VALUE (0 at default), whatever its prior value.
REQ-014 Reset asserted mid-count SHALL win over the increment at that edge.
REQ-015 Reset held over several edges SHALL keep out at RESET_VALUE.
REQ-016 Reset SHALL have no effect between clock edges, because it is synchronous.
REQ-017 Before the first reset edge, out is undefined; no power-up initializer is required, and benches SHALL NOT check out before the first reset.

Structure
REQ-018 The block SHALL be a single module with one WIDTH-bit register and an incrementer, with no sub-modules.
REQ-019 No shared package is needed; WIDTH and RESET_VALUE are module parameters only.
REQ-020 The block SHALL be synthesizable with no latches and no initial blocks.

Verification
Timing for all scenarios: clk period 10, first rising edge at t=5.
REQ-021 Drive reset=1 over t=17..28 -> at t=25, out=0x00.
REQ-022 Release reset at t=28 -> out=1, 2, 3 at t=35, 45, 55.
REQ-023 Reassert reset over t=57..68, mid-count -> out=0 at t=65, and out=1 at t=75.
REQ-024 Free-run after t=68 -> out=0x0A (10) at t=165, incrementing by exactly 1 per edge.
REQ-025 Free-run 256 edges from reset -> out passes 0xFF then 0x00 (wrap), with no missing or repeated value.
REQ-026 Hold reset high for 3 consecutive edges, with WIDTH=4 and RESET_VALUE=5 -> out stays 5; the first edge after release gives 6; 0xF then wraps to 0x0.
